// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequencer slice: ALU operation codes,
// opcode values, branch kinds and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GE
  } br_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-field / ALU / result handshake bundle for alu_sequencer.
// slave = the sequencer, master = the environment driving it.
interface alu_sequencer_if;
  logic        inValid;
  logic        inReady;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [3:0]  ALUControl;
  logic [31:0] ALUOut;
  logic        zero;
  logic [31:0] result;
  logic        branchTaken;
  logic        illegal;
  logic        outValid;
  logic        outReady;

  modport slave (
    input  inValid, opcode, funct3, funct7b5, ALUOut, zero, outReady,
    output inReady, ALUControl, result, branchTaken, illegal, outValid
  );

  modport master (
    output inValid, opcode, funct3, funct7b5, ALUOut, zero, outReady,
    input  inReady, ALUControl, result, branchTaken, illegal, outValid
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational field decoder: opcode/funct3/funct7b5 -> ALU code, branch kind, illegal.
// Optional macro ALU_SEQUENCER_ILLEGAL_EN enables reporting of undecodable fields.
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] code,
  output br_kind_t   kind,
  output logic       illegal
);

  logic [3:0] raw_code;
  logic       bad;

  always_comb begin
    raw_code = ALU_ADD;
    kind     = BR_NONE;
    bad      = 1'b0;
    unique case (opcode)
      OP_RTYPE, OP_ITYPE: begin
        case (funct3)
          3'b000:  raw_code = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  raw_code = ALU_AND;
          3'b110:  raw_code = ALU_OR;
          3'b010:  raw_code = ALU_SLT;
          default: bad = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: raw_code = ALU_ADD;
      OP_BRANCH: begin
        case (funct3)
          3'b000: begin raw_code = ALU_SUB; kind = BR_EQ; end
          3'b001: begin raw_code = ALU_SUB; kind = BR_NE; end
          3'b100: begin raw_code = ALU_SLT; kind = BR_LT; end
          3'b101: begin raw_code = ALU_SLT; kind = BR_GE; end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

`ifdef ALU_SEQUENCER_ILLEGAL_EN
  assign illegal = bad;
  assign code    = raw_code;
`else
  // Undecodable fields fall back to a plain ADD with no branch outcome.
  assign illegal = 1'b0;
  assign code    = bad ? ALU_ADD : raw_code;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Three-state sequencer: accepts instruction fields, issues one ALU op, captures the outcome.
// With ALU_SEQUENCER_ILLEGAL_EN defined, undecodable fields skip ISSUE and report illegal.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  alu_sequencer_if.slave        bus
);

  state_t     state_q, state_d;
  logic [3:0] code_q;
  br_kind_t   kind_q;
  logic [31:0] result_q;
  logic       taken_q;
  logic       illegal_q;
  logic       taken_d;

  logic [3:0] dec_code;
  br_kind_t   dec_kind;
  logic       dec_illegal;

  alu_decode u_decode (
    .opcode   (bus.opcode),
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .code     (dec_code),
    .kind     (dec_kind),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    taken_d = 1'b0;
    case (kind_q)
      BR_EQ:   taken_d = bus.zero;
      BR_NE:   taken_d = !bus.zero;
      BR_LT:   taken_d = bus.ALUOut[0];
      BR_GE:   taken_d = !bus.ALUOut[0];
      default: taken_d = 1'b0;
    endcase
    case (state_q)
      S_IDLE:  if (bus.inValid) state_d = dec_illegal ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_DONE;
      S_DONE:  if (bus.outReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      code_q    <= ALU_AND;
      kind_q    <= BR_NONE;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.inValid) begin
            // Illegal fields leave the issued code untouched and produce a zero outcome.
            if (dec_illegal) begin
              illegal_q <= 1'b1;
              result_q  <= '0;
              taken_q   <= 1'b0;
            end else begin
              illegal_q <= 1'b0;
              code_q    <= dec_code;
              kind_q    <= dec_kind;
            end
          end
        end
        S_ISSUE: begin
          result_q <= bus.ALUOut;
          taken_q  <= taken_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.inReady     = (state_q == S_IDLE);
  assign bus.outValid    = (state_q == S_DONE);
  assign bus.ALUControl  = code_q;
  assign bus.result      = result_q;
  assign bus.branchTaken = taken_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, stall/reset sequences,
// and randomized transactions against a mnemonic-level reference model.
module tb_alu_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] last_code = 4'b0000;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] aout;
    logic        z;
    logic [3:0]  code;
    logic        taken;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic [31:0] aout, input logic z, input logic [3:0] code,
                              input logic taken, input logic ill);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.aout = aout; v.z = z;
    v.code = code; v.taken = taken; v.ill = ill;
    return v;
  endfunction

  // Reference: name the instruction first, then derive code, branch outcome and legality.
  function automatic vec_t ref_model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] aout, input logic z);
    vec_t  v;
    string name;
    name = "none";
    if (op == 7'h33 || op == 7'h13) begin
      if (f3 == 3'd0)      name = (op == 7'h33 && f7) ? "sub" : "add";
      else if (f3 == 3'd7) name = "and";
      else if (f3 == 3'd6) name = "or";
      else if (f3 == 3'd2) name = "slt";
    end else if (op == 7'h03 || op == 7'h23) begin
      name = "add";
    end else if (op == 7'h63) begin
      if (f3 == 3'd0)      name = "beq";
      else if (f3 == 3'd1) name = "bne";
      else if (f3 == 3'd4) name = "blt";
      else if (f3 == 3'd5) name = "bge";
    end
    v.op = op; v.f3 = f3; v.f7 = f7; v.aout = aout; v.z = z;
    v.taken = 1'b0;
    v.ill   = 1'b0;
    case (name)
      "and":         v.code = 4'd0;
      "or":          v.code = 4'd1;
      "add":         v.code = 4'd2;
      "sub":         v.code = 4'd6;
      "slt":         v.code = 4'd7;
      "beq", "bne":  v.code = 4'd6;
      "blt", "bge":  v.code = 4'd7;
      default: begin
        v.code = 4'd2;
`ifdef ALU_SEQUENCER_ILLEGAL_EN
        v.ill  = 1'b1;
`endif
      end
    endcase
    if (name == "beq") v.taken = z;
    if (name == "bne") v.taken = !z;
    if (name == "blt") v.taken = aout[0];
    if (name == "bge") v.taken = !aout[0];
    return v;
  endfunction

  // Full transaction starting and ending on a negedge, outReady raised once DONE is checked.
  task automatic do_txn(input vec_t v, input string tag);
    int unsigned guard;
    guard = 0;
    while (!bus.inReady && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check({tag, ".ready_wait"}, {31'd0, bus.inReady}, 32'd1);
    bus.opcode = v.op; bus.funct3 = v.f3; bus.funct7b5 = v.f7;
    bus.inValid = 1'b1; bus.outReady = 1'b0;
    @(negedge clock);
    bus.inValid = 1'b0;
    if (v.ill) begin
      check({tag, ".ill_outValid"}, {31'd0, bus.outValid}, 32'd1);
      check({tag, ".ill_flag"}, {31'd0, bus.illegal}, 32'd1);
      check({tag, ".ill_result"}, bus.result, 32'd0);
      check({tag, ".ill_taken"}, {31'd0, bus.branchTaken}, 32'd0);
      check({tag, ".ill_ALUControl"}, {28'd0, bus.ALUControl}, {28'd0, last_code});
    end else begin
      check({tag, ".issue_outValid"}, {31'd0, bus.outValid}, 32'd0);
      check({tag, ".issue_inReady"}, {31'd0, bus.inReady}, 32'd0);
      check({tag, ".issue_ALUControl"}, {28'd0, bus.ALUControl}, {28'd0, v.code});
      bus.ALUOut = v.aout; bus.zero = v.z;
      @(negedge clock);
      check({tag, ".done_outValid"}, {31'd0, bus.outValid}, 32'd1);
      check({tag, ".done_result"}, bus.result, v.aout);
      check({tag, ".done_taken"}, {31'd0, bus.branchTaken}, {31'd0, v.taken});
      check({tag, ".done_illegal"}, {31'd0, bus.illegal}, 32'd0);
      check({tag, ".done_ALUControl"}, {28'd0, bus.ALUControl}, {28'd0, v.code});
      last_code = v.code;
    end
    bus.ALUOut = $urandom; bus.zero = ~v.z;
    bus.outReady = 1'b1;
    @(negedge clock);
    check({tag, ".ret_inReady"}, {31'd0, bus.inReady}, 32'd1);
    check({tag, ".ret_outValid"}, {31'd0, bus.outValid}, 32'd0);
    bus.outReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    bus.inValid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.ALUOut = '0; bus.zero = 1'b0; bus.outReady = 1'b0;

    vecs.push_back(mk(7'h33, 3'd0, 1'b1, 32'h0000_0005, 1'b0, 4'b0110, 1'b0, 1'b0));
    vecs.push_back(mk(7'h33, 3'd0, 1'b0, 32'h1234_5678, 1'b0, 4'b0010, 1'b0, 1'b0));
    vecs.push_back(mk(7'h33, 3'd7, 1'b0, 32'h0000_00F0, 1'b1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(7'h33, 3'd6, 1'b1, 32'hFFFF_0000, 1'b0, 4'b0001, 1'b0, 1'b0));
    vecs.push_back(mk(7'h33, 3'd2, 1'b0, 32'h0000_0001, 1'b0, 4'b0111, 1'b0, 1'b0));
    vecs.push_back(mk(7'h13, 3'd0, 1'b1, 32'h0000_0042, 1'b0, 4'b0010, 1'b0, 1'b0));
    vecs.push_back(mk(7'h13, 3'd7, 1'b0, 32'hA5A5_A5A5, 1'b0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(7'h03, 3'd2, 1'b0, 32'h0000_1000, 1'b1, 4'b0010, 1'b0, 1'b0));
    vecs.push_back(mk(7'h23, 3'd2, 1'b1, 32'h0000_2004, 1'b0, 4'b0010, 1'b0, 1'b0));
    vecs.push_back(mk(7'h63, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 4'b0110, 1'b1, 1'b0));
    vecs.push_back(mk(7'h63, 3'd0, 1'b0, 32'h0000_0003, 1'b0, 4'b0110, 1'b0, 1'b0));
    vecs.push_back(mk(7'h63, 3'd1, 1'b0, 32'h0000_0003, 1'b0, 4'b0110, 1'b1, 1'b0));
    vecs.push_back(mk(7'h63, 3'd4, 1'b0, 32'h0000_0001, 1'b0, 4'b0111, 1'b1, 1'b0));
    vecs.push_back(mk(7'h63, 3'd5, 1'b0, 32'h0000_0001, 1'b0, 4'b0111, 1'b0, 1'b0));
    vecs.push_back(mk(7'h63, 3'd5, 1'b0, 32'h0000_0000, 1'b0, 4'b0111, 1'b1, 1'b0));
`ifdef ALU_SEQUENCER_ILLEGAL_EN
    vecs.push_back(mk(7'h7F, 3'd0, 1'b0, 32'h0000_0009, 1'b1, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk(7'h63, 3'd2, 1'b0, 32'h0000_0007, 1'b1, 4'b0000, 1'b0, 1'b1));
`else
    vecs.push_back(mk(7'h7F, 3'd0, 1'b0, 32'h0000_0009, 1'b1, 4'b0010, 1'b0, 1'b0));
    vecs.push_back(mk(7'h63, 3'd2, 1'b0, 32'h0000_0007, 1'b1, 4'b0010, 1'b0, 1'b0));
`endif

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset.inReady", {31'd0, bus.inReady}, 32'd1);
    check("reset.outValid", {31'd0, bus.outValid}, 32'd0);
    check("reset.ALUControl", {28'd0, bus.ALUControl}, 32'd0);
    check("reset.result", bus.result, 32'd0);
    check("reset.branchTaken", {31'd0, bus.branchTaken}, 32'd0);
    check("reset.illegal", {31'd0, bus.illegal}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Stall in DONE with inValid held high: outputs frozen, nothing accepted.
    bus.opcode = 7'h33; bus.funct3 = 3'd0; bus.funct7b5 = 1'b1;
    bus.inValid = 1'b1; bus.outReady = 1'b0;
    @(negedge clock);
    bus.opcode = 7'h33; bus.funct3 = 3'd7; bus.funct7b5 = 1'b0;
    bus.ALUOut = 32'hDEAD_0001; bus.zero = 1'b1;
    @(negedge clock);
    check("stall.enter_outValid", {31'd0, bus.outValid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      bus.opcode = 7'h13; bus.funct3 = 3'($urandom); bus.ALUOut = $urandom;
      @(negedge clock);
      check($sformatf("stall%0d.result", c), bus.result, 32'hDEAD_0001);
      check($sformatf("stall%0d.outValid", c), {31'd0, bus.outValid}, 32'd1);
      check($sformatf("stall%0d.inReady", c), {31'd0, bus.inReady}, 32'd0);
      check($sformatf("stall%0d.ALUControl", c), {28'd0, bus.ALUControl}, 32'h6);
      check($sformatf("stall%0d.taken", c), {31'd0, bus.branchTaken}, 32'd0);
    end
    bus.outReady = 1'b1; bus.inValid = 1'b0;
    @(negedge clock);
    bus.outReady = 1'b0;
    check("stall.release_inReady", {31'd0, bus.inReady}, 32'd1);
    check("stall.release_outValid", {31'd0, bus.outValid}, 32'd0);
    check("stall.no_second_accept", {28'd0, bus.ALUControl}, 32'h6);
    @(negedge clock);
    check("stall.idle_hold", {31'd0, bus.inReady}, 32'd1);
    last_code = 4'b0110;

    // Reset asserted while ISSUE is in progress.
    bus.opcode = 7'h33; bus.funct3 = 3'd0; bus.funct7b5 = 1'b1; bus.inValid = 1'b1;
    @(negedge clock);
    bus.inValid = 1'b0; bus.ALUOut = 32'h0BAD_0BAD;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_issue.outValid", {31'd0, bus.outValid}, 32'd0);
    check("rst_issue.result", bus.result, 32'd0);
    check("rst_issue.ALUControl", {28'd0, bus.ALUControl}, 32'd0);
    check("rst_issue.inReady", {31'd0, bus.inReady}, 32'd1);
    check("rst_issue.taken", {31'd0, bus.branchTaken}, 32'd0);
    last_code = 4'b0000;

    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 6))
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h03;
        3: op = 7'h23;
        4: op = 7'h63;
        5: op = 7'h63;
        default: op = 7'($urandom);
      endcase
      v = ref_model(op, 3'($urandom), 1'($urandom), $urandom, 1'($urandom));
      do_txn(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
